// File: rtl/rtype_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// rtype_multicycle_ctrl
//
// Multicycle sequencer for the R-type MIPS datapath. Each instruction is
// split into FETCH / DECODE / EXECUTE / WRITEBACK, and the sequencer produces
// the load enables for the PC, the instruction register (IR), the ALUOut
// boundary register and the register file. It also decodes op/func into the
// 4-bit ALU control, flags illegal encodings (sticky), stops in HALT on the
// halt opcode, and counts retired instructions with a saturating counter.
//
// Handshake: the only handshake is instruction fetch. imem_ready is a
// level-valid qualifier on the instruction memory data; the sequencer waits
// in FETCH while it is low and consumes the word (ir_we/pc_we pulse) in the
// first FETCH cycle where it is high. There is no backpressure toward memory.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   run          in   1 = execute; sampled only at instruction boundaries
//   op           in   IR[31:26], valid from DECODE onward
//   func         in   IR[5:0], valid from DECODE onward
//   imem_ready   in   instruction memory data valid
//   pc_we        out  PC load enable (PC <= PC+4)
//   ir_we        out  instruction register load enable
//   aluout_we    out  ALUOut register load enable
//   reg_we       out  register file write enable (rd)
//   alu_cntl     out  ALU operation select, latched at end of DECODE
//   busy         out  1 in any state except IDLE and HALT
//   halted       out  1 in HALT
//   illegal      out  sticky flag: an illegal instruction was executed
//   instr_count  out  retired instruction count, saturating at all-ones
//   dbg_state    out  current FSM state encoding (observability)
// ---------------------------------------------------------------------------
module rtype_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             imem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             aluout_we,
    output logic             reg_we,
    output logic [3:0]       alu_cntl,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       dbg_state
);

    // State encoding is fixed so that dbg_state values are stable for
    // anyone watching the sequencer from outside.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic       cur_legal;   // legality of the instruction now in EXECUTE
    logic [3:0] dec_cntl;
    logic       dec_legal;
    logic       dec_halt;

    // -----------------------------------------------------------------------
    // op/func decode. Only meaningful while in DECODE, where op/func are
    // guaranteed valid; the result is captured on the DECODE exit edge.
    // Anything unrecognised decodes to AND (4'b0000) and is marked illegal.
    // The halt opcode is not illegal; it is steered separately.
    // -----------------------------------------------------------------------
    always_comb begin
        dec_cntl  = ALU_AND;
        dec_legal = 1'b0;
        dec_halt  = (op == OP_HALT);
        if (op == OP_RTYPE) begin
            dec_legal = 1'b1;
            case (func)
                FN_ADD:  dec_cntl = ALU_ADD;
                FN_SUB:  dec_cntl = ALU_SUB;
                FN_AND:  dec_cntl = ALU_AND;
                FN_OR:   dec_cntl = ALU_OR;
                FN_NOR:  dec_cntl = ALU_NOR;
                FN_SLT:  dec_cntl = ALU_SLT;
                default: begin
                    dec_cntl  = ALU_AND;
                    dec_legal = 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer plus the registered outputs it owns (alu_cntl, illegal,
    // instr_count). run is only consulted in IDLE and on the two
    // instruction-boundary exits (EXECUTE-illegal, WRITEBACK), so dropping it
    // mid-instruction always lets the current instruction finish.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            alu_cntl    <= ALU_AND;
            cur_legal   <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // Stall until memory presents the word.
                    if (imem_ready) begin
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    alu_cntl  <= dec_cntl;
                    cur_legal <= dec_legal;
                    if (dec_halt) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end

                S_EXECUTE: begin
                    if (cur_legal) begin
                        state <= S_WRITEBACK;
                    end else begin
                        // Illegal: the ALUOut load has happened but the
                        // result is dropped; no writeback, no retire count.
                        illegal <= 1'b1;
                        state   <= run ? S_FETCH : S_IDLE;
                    end
                end

                S_WRITEBACK: begin
                    if (instr_count != CNT_MAX) begin
                        instr_count <= instr_count + 1'b1;
                    end
                    state <= run ? S_FETCH : S_IDLE;
                end

                S_HALT: begin
                    // Absorbing; only reset leaves.
                    state <= S_HALT;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Enables are decoded straight from the state register so that an
    // asynchronous reset removes them immediately (no write can slip out
    // after reset is asserted). The FETCH pulses are additionally qualified
    // by imem_ready so the IR/PC load exactly once, on the ready cycle.
    // Because each enable belongs to a different state, at most one of
    // pc_we/aluout_we/reg_we can be high at a time.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_we     = (state == S_FETCH) && imem_ready;
        ir_we     = (state == S_FETCH) && imem_ready;
        aluout_we = (state == S_EXECUTE);
        reg_we    = (state == S_WRITEBACK);
        busy      = (state == S_FETCH)   || (state == S_DECODE) ||
                    (state == S_EXECUTE) || (state == S_WRITEBACK);
        halted    = (state == S_HALT);
        dbg_state = state;
    end

endmodule

// File: tb/tb_rtype_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rtype_multicycle_ctrl
//
// Directed bench for the multicycle R-type sequencer. A second instance with
// a 2-bit counter shares all inputs so counter saturation is reachable in a
// handful of instructions. Expected ALU controls are queued when an
// instruction is presented and checked when the DUT reaches EXECUTE.
// ---------------------------------------------------------------------------
module tb_rtype_multicycle_ctrl;

    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic             run;
    logic [5:0]       op;
    logic [5:0]       func;
    logic             imem_ready;
    logic             pc_we, ir_we, aluout_we, reg_we;
    logic [3:0]       alu_cntl;
    logic             busy, halted, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       dbg_state;

    logic             s_pc_we, s_ir_we, s_aluout_we, s_reg_we;
    logic [3:0]       s_alu_cntl;
    logic             s_busy, s_halted, s_illegal;
    logic [1:0]       s_instr_count;
    logic [2:0]       s_dbg_state;

    rtype_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .op          (op),
        .func        (func),
        .imem_ready  (imem_ready),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .aluout_we   (aluout_we),
        .reg_we      (reg_we),
        .alu_cntl    (alu_cntl),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    rtype_multicycle_ctrl #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .op          (op),
        .func        (func),
        .imem_ready  (imem_ready),
        .pc_we       (s_pc_we),
        .ir_we       (s_ir_we),
        .aluout_we   (s_aluout_we),
        .reg_we      (s_reg_we),
        .alu_cntl    (s_alu_cntl),
        .busy        (s_busy),
        .halted      (s_halted),
        .illegal     (s_illegal),
        .instr_count (s_instr_count),
        .dbg_state   (s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // EXECUTE-cycle monitor: pop the expected ALU control for the instruction
    // being executed. Also checks datapath enables never overlap.
    always @(negedge clk) begin
        if (reset) begin
            if (aluout_we) begin
                if (exp_q.size() == 0) begin
                    check("alu_cntl_unexpected_exec", 32'd1, 32'd0);
                end else begin
                    check("alu_cntl_exec", {28'd0, alu_cntl}, {28'd0, exp_q.pop_front()});
                end
            end
            check("enables_exclusive",
                  32'(int'(pc_we) + int'(aluout_we) + int'(reg_we)) <= 32'd1 ? 32'd1 : 32'd0,
                  32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the DUT in FETCH and imem_ready=1; runs one legal
    // instruction through F/D/E/W and leaves the DUT past WRITEBACK.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic [3:0] c);
        op   = o;
        func = f;
        exp_q.push_back(c);
        #1;
        check("f_state", {29'd0, dbg_state}, 32'd1);
        check("f_pc_we", {31'd0, pc_we}, 32'd1);
        check("f_ir_we", {31'd0, ir_we}, 32'd1);
        tick();
        check("d_state", {29'd0, dbg_state}, 32'd2);
        check("d_pc_we", {31'd0, pc_we}, 32'd0);
        tick();
        check("e_state", {29'd0, dbg_state}, 32'd3);
        check("e_aluout_we", {31'd0, aluout_we}, 32'd1);
        check("e_reg_we", {31'd0, reg_we}, 32'd0);
        tick();
        check("w_state", {29'd0, dbg_state}, 32'd4);
        check("w_reg_we", {31'd0, reg_we}, 32'd1);
        check("w_alu_hold", {28'd0, alu_cntl}, {28'd0, c});
        tick();
    endtask

    // Same entry condition; illegal instruction goes F/D/E then back to FETCH.
    task automatic do_illegal(input logic [5:0] o, input logic [5:0] f, input logic [CNT_W-1:0] cnt);
        op   = o;
        func = f;
        exp_q.push_back(4'b0000);
        tick();
        check("il_d_state", {29'd0, dbg_state}, 32'd2);
        tick();
        check("il_e_state", {29'd0, dbg_state}, 32'd3);
        tick();
        check("il_back_fetch", {29'd0, dbg_state}, 32'd1);
        check("il_flag", {31'd0, illegal}, 32'd1);
        check("il_count", {16'd0, instr_count}, {16'd0, cnt});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1;
        run = 1'b0;
        op = 6'd0;
        func = 6'd0;
        imem_ready = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_alu", {28'd0, alu_cntl}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_enables", {28'd0, pc_we, ir_we, aluout_we, reg_we}, 32'd0);
        check("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
        reset = 1'b1;
        tick();
        check("idle_hold", {29'd0, dbg_state}, 32'd0);

        // Single add, state sequence 1,2,3,4,1.
        run = 1'b1;
        tick();
        check("busy_fetch", {31'd0, busy}, 32'd1);
        do_instr(6'h00, 6'h20, 4'b0010);
        check("add_next_fetch", {29'd0, dbg_state}, 32'd1);
        check("add_count", {16'd0, instr_count}, 32'd1);

        // Three stall cycles in FETCH, then ready.
        imem_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_state", {29'd0, dbg_state}, 32'd1);
            check("stall_pc_we", {31'd0, pc_we}, 32'd0);
            check("stall_ir_we", {31'd0, ir_we}, 32'd0);
            if (i < 2) tick();
        end
        tick();
        imem_ready = 1'b1;
        do_instr(6'h00, 6'h20, 4'b0010);
        check("stall_count", {16'd0, instr_count}, 32'd2);

        // sub, and, or, nor, slt back-to-back.
        do_instr(6'h00, 6'h22, 4'b0110);
        do_instr(6'h00, 6'h24, 4'b0000);
        do_instr(6'h00, 6'h25, 4'b0001);
        do_instr(6'h00, 6'h27, 4'b1100);
        do_instr(6'h00, 6'h2A, 4'b0111);
        check("seq_count", {16'd0, instr_count}, 32'd7);
        check("sat_count", {30'd0, s_instr_count}, 32'd3);
        check("seq_illegal", {31'd0, illegal}, 32'd0);

        // Illegal func, then illegal op; flag sticks, count unchanged.
        do_illegal(6'h00, 6'h08, 16'd7);
        do_illegal(6'h23, 6'h20, 16'd7);
        do_instr(6'h00, 6'h20, 4'b0010);
        check("illegal_sticky", {31'd0, illegal}, 32'd1);
        check("post_illegal_count", {16'd0, instr_count}, 32'd8);

        // Drop run during EXECUTE: WRITEBACK still happens, then IDLE.
        op = 6'h00;
        func = 6'h25;
        exp_q.push_back(4'b0001);
        tick();
        tick();
        check("rd_e_state", {29'd0, dbg_state}, 32'd3);
        run = 1'b0;
        tick();
        check("rd_wb", {31'd0, reg_we}, 32'd1);
        tick();
        check("rd_idle", {29'd0, dbg_state}, 32'd0);
        check("rd_busy", {31'd0, busy}, 32'd0);
        check("rd_count", {16'd0, instr_count}, 32'd9);

        // Halt: F, D, then HALT; absorbing with run=1.
        op = 6'h3F;
        func = 6'h00;
        run = 1'b1;
        tick();
        check("h_fetch", {29'd0, dbg_state}, 32'd1);
        tick();
        check("h_decode", {29'd0, dbg_state}, 32'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("h_state", {29'd0, dbg_state}, 32'd5);
            check("h_halted", {31'd0, halted}, 32'd1);
            check("h_busy", {31'd0, busy}, 32'd0);
            check("h_enables", {28'd0, pc_we, ir_we, aluout_we, reg_we}, 32'd0);
            tick();
        end
        reset = 1'b0;
        #1;
        check("h_rst_state", {29'd0, dbg_state}, 32'd0);
        check("h_rst_count", {16'd0, instr_count}, 32'd0);
        check("h_rst_halted", {31'd0, halted}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_halt_fetch", {29'd0, dbg_state}, 32'd1);
        do_instr(6'h00, 6'h22, 4'b0110);
        check("post_halt_count", {16'd0, instr_count}, 32'd1);

        // Async reset during WRITEBACK aborts the write immediately.
        op = 6'h00;
        func = 6'h20;
        exp_q.push_back(4'b0010);
        tick();
        tick();
        tick();
        check("ar_wb_state", {29'd0, dbg_state}, 32'd4);
        check("ar_wb_reg_we", {31'd0, reg_we}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_reg_we", {31'd0, reg_we}, 32'd0);
        check("ar_state", {29'd0, dbg_state}, 32'd0);
        check("ar_count", {16'd0, instr_count}, 32'd0);
        check("ar_alu", {28'd0, alu_cntl}, 32'd0);
        tick();
        check("ar_no_wb_later", {16'd0, instr_count}, 32'd0);

        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
